ifetch_line_ctrl: RTL
=====================

Name: ifetch_line_ctrl

Overview:
Instruction-fetch responder on the consumer side of the PC register. It takes the fetch address from the PC, returns the instruction word, and asserts a stall back to the PC/hazard logic while a miss is serviced. It keeps a small direct-mapped line buffer. On a miss it fetches a full line from slow instruction memory over a req/ack handshake.

Parameters:
ENTRIES, 4, number of direct-mapped lines (power of 2, ≥2)
LINE_WORDS, 4, 32-bit words per line (fixed; memory line width 128 bits)
CNT_W, 16, width of miss counter

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  CPU run enable; low = no fetch activity
pc_i  input  32  fetch byte address from PC; bits [1:0] ignored
flush_i  input  1  invalidate all lines (one-cycle pulse)
instr_o  output  32  fetched instruction; 0 (NOP) when not valid
stall_o  output  1  hold PC and IF/ID; high while the fetch cannot complete this cycle
mem_req_o  output  1  line read request to instruction memory
mem_addr_o  output  32  line-aligned read address (bits [3:0] = 0)
mem_ack_i  input  1  one-cycle pulse: mem_data_i valid
mem_data_i  input  128  line data; word k at bits [32k+31:32k]
miss_cnt_o  output  CNT_W  saturating count of misses started

Behaviour:
- Address split (ENTRIES=4): offset pc_i[3:2], index pc_i[5:4], tag pc_i[31:6]. In general, index width is log2(ENTRIES) and the tag is the remaining upper bits.
- Storage per line: valid bit, tag, 128-bit data. Valid bits, state, mem_req_o, mem_addr_o and miss_cnt_o are reset to 0. Tag and data storage are not reset.
- hit = start_i & valid[index] & (tag[index] == pc_i tag), evaluated combinationally on current pc_i.
- instr_o is combinational: the selected word of the indexed line when hit, else 32'b0.
- stall_o is combinational: start_i & (state != IDLE | ~hit).
- States:
  - IDLE: on start_i & ~hit, latch the line address {pc_i[31:4],4'b0} into mem_addr_o, set mem_req_o=1, increment miss_cnt_o (saturates at all-ones), go to READ. Otherwise stay in IDLE.
  - READ: hold mem_req_o=1 and mem_addr_o stable. On mem_ack_i:
    - write mem_data_i and the latched tag into the line at the latched index;
    - set its valid bit unless flush_i is high in the same cycle;
    - clear mem_req_o and go to IDLE.
  - Returning to IDLE re-evaluates hit on the next cycle.
- Miss penalty: miss detected at cycle 0; mem_req_o high from cycle 1; ack at cycle N; hit and stall_o=0 at cycle N+1 (if pc_i is unchanged).
- mem_ack_i is ignored in IDLE: no write, no state change.
- pc_i changing during READ does not affect the fill. The fill goes to the latched address, and the new pc_i is re-evaluated in IDLE afterwards (possibly another miss).
- flush_i clears all valid bits at the clock edge, in any state. An in-flight READ continues and completes. Flush wins over the fill's valid set in the same cycle.
- start_i low:
  - stall_o=0 and instr_o=0;
  - no new request is issued;
  - an in-flight READ still completes its fill and returns to IDLE;
  - stored lines are retained.
- rst_i asserted at any time (including mid-READ) immediately:
  - forces IDLE;
  - drops mem_req_o;
  - clears all valid bits and miss_cnt_o.
- An ack arriving after reset is ignored.
- Exactly one outstanding request at any time.

Test Plan:
1. Cold miss: reset, start_i=1, pc_i=0x00000008, ack 3 cycles after req with line {0x44,0x33,0x22,0x11} (word0=0x11) -> stall_o=1 from cycle 0; mem_addr_o=0x0; next cycle after ack stall_o=0, instr_o=0x33; miss_cnt_o=1.
2. Hits within and across a line: after test 1, pc_i 0x0,0x4,0xC on consecutive cycles -> instr_o 0x11,0x22,0x44 with stall_o=0 and no mem_req_o; pc_i=0x10 -> miss, mem_addr_o=0x10.
3. Conflict: fill pc=0x00 then pc=0x40 (same index 0, different tag) -> second access misses; afterwards 0x00 misses again; miss_cnt_o=3.
4. Flush coincident with ack: flush_i=1 in the ack cycle for pc=0x20 -> following cycle stall_o=1 and a new req to 0x20 (line not valid).
5. Reset mid-READ: assert rst_i two cycles after mem_req_o rises, release, then pulse mem_ack_i -> mem_req_o=0 immediately; no line becomes valid; miss_cnt_o=0; a fetch of the same pc misses.
6. start_i low during READ: deassert start_i while waiting -> stall_o=0 and instr_o=0; the ack still fills; start_i=1 on the same pc -> hit without a new request.

Source files
------------

// File: rtl/ifetch_line_ctrl.sv
// Instruction-fetch line buffer: direct-mapped, single outstanding line fill over req/ack.
// Stalls the PC while a miss is serviced; returns NOP when no hit.
module ifetch_line_ctrl #(
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [31:0]               pc_i,
  input  logic                      flush_i,
  output logic [31:0]               instr_o,
  output logic                      stall_o,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  input  logic                      mem_ack_i,
  input  logic [32*LINE_WORDS-1:0]  mem_data_i,
  output logic [CNT_W-1:0]          miss_cnt_o
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = 32 - 4 - IdxW;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill;

  logic [ENTRIES-1:0]                valid_q;
  logic [TagW-1:0]                   tag_q  [ENTRIES];
  logic [LINE_WORDS-1:0][31:0]       data_q [ENTRIES];

  logic [IdxW-1:0] pc_idx, fill_idx;
  logic [TagW-1:0] pc_tag, fill_tag;
  logic [1:0]      pc_off;
  logic            hit;
  logic            unused_pc;

  assign pc_off    = pc_i[3:2];
  assign pc_idx    = pc_i[4 +: IdxW];
  assign pc_tag    = pc_i[31 -: TagW];
  assign fill_idx  = addr_q[4 +: IdxW];
  assign fill_tag  = addr_q[31 -: TagW];
  assign unused_pc = ^pc_i[1:0];

  assign hit     = start_i & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
  assign instr_o = hit ? data_q[pc_idx][pc_off] : 32'b0;
  assign stall_o = start_i & ((state_q != StIdle) | ~hit);

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign miss_cnt_o = cnt_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fill    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !hit) begin
          addr_d  = {pc_i[31:4], 4'b0};
          req_d   = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = StRead;
        end
      end
      StRead: begin
        // The fill completes even with start_i low; target is the latched address.
        if (mem_ack_i) begin
          fill    = 1'b1;
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush beats the valid set of a coincident fill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data_i;
    end
  end

endmodule
